jk_bank_arbiter: RTL and testbench
==================================

Name: jk_bank_arbiter

Overview:
- Owns a bank of N_BITS JK flip-flop cells and shares their single update port between two requesters.
- Each requester issues JK commands (hold/reset/set/toggle) to an addressed cell through a valid/ready handshake.
- A round-robin arbiter grants at most one command per cycle.
- Sits between control logic and any downstream consumer of the q/qb state bits.

Parameters:
- N_BITS, 6, number of JK cells in the bank.
- ADDR_W, 3, width of the cell address.
- CNT_W, 8, width of the accepted-command counter.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0_valid  input  1  requester 0 has a command.
- req0_addr  input  ADDR_W  requester 0 target cell.
- req0_j  input  1  requester 0 J input.
- req0_k  input  1  requester 0 K input.
- req0_ready  output  1  requester 0 command accepted this cycle (combinational).
- req1_valid  input  1  requester 1 has a command.
- req1_addr  input  ADDR_W  requester 1 target cell.
- req1_j  input  1  requester 1 J input.
- req1_k  input  1  requester 1 K input.
- req1_ready  output  1  requester 1 command accepted this cycle (combinational).
- q  output  N_BITS  cell states.
- qb  output  N_BITS  bitwise complement of q.
- ack0  output  1  registered pulse, one cycle after a requester 0 accept.
- ack1  output  1  registered pulse, one cycle after a requester 1 accept.
- addr_err  output  1  registered pulse, one cycle after an accept with addr >= N_BITS.
- cmd_count  output  CNT_W  number of accepted commands, saturating.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - q = 0, qb = all ones.
  - ack0 = ack1 = addr_err = 0, cmd_count = 0.
  - Priority pointer prio = 0, meaning requester 0 is favoured.
- While reset is high: req0_ready = req1_ready = 0 and no command is accepted.
- Arbitration, combinational, evaluated each cycle:
  - Only req0_valid: req0_ready = 1.
  - Only req1_valid: req1_ready = 1.
  - Both valid: req{prio}_ready = 1 and the other ready = 0.
  - Neither valid: both ready = 0.
  - Never both ready in the same cycle.
  - A ready never asserts without its own valid.
- Accept = valid && ready, sampled at the rising clk edge. At that edge:
  - Addressed cell updates per JK rules from its current value: JK=00 hold, 01 q=0, 10 q=1, 11 q=~q.
  - New q is visible in the cycle after the edge, so latency from accept to q change is 1 clock.
  - qb always equals ~q for every bit, including during and after reset.
  - Unaddressed cells are unchanged.
  - If addr >= N_BITS: no cell changes, the command still counts as accepted, and addr_err pulses high for the following cycle.
- Priority update:
  - prio toggles to the other requester only when both were valid in that cycle and the favoured one was granted.
  - A single-requester grant leaves prio unchanged.
  - Net effect: under continuous contention grants strictly alternate 0,1,0,1...
- ack0/ack1 are high for exactly one cycle following each accept of the corresponding requester. Back-to-back accepts give ack held high on consecutive cycles.
- cmd_count increments by 1 per accept and saturates at 2^CNT_W-1 (no wrap).
- Requesters hold valid and payload stable until accepted. A payload change while valid && !ready is legal; the value sampled at the accepting edge is the one used.
- The losing requester's command is not stored. It remains pending on its inputs.
- Reset asserted mid-operation clears every register immediately. A command whose accept edge coincides with reset assertion is discarded.

Test Plan:
- Reset: assert reset for 3 cycles, release -> q=000000, qb=111111, ack0=ack1=addr_err=0, cmd_count=0, both ready=0 while reset is high.
- Single requester: req0 addr=2 JK=10 for one cycle -> q[2]=1 next cycle, ack0 pulses once. Then JK=11 -> q[2]=0. Then JK=11 -> q[2]=1. Then JK=01 -> q[2]=0. Then JK=00 -> q unchanged. cmd_count=5.
- Contention: both valid for 6 cycles, req0 addr=0 JK=11, req1 addr=1 JK=11 -> grants alternate 0,1,0,1,0,1, q[0] and q[1] each toggle 3 times to end at 1, cmd_count=6, ready never both high.
- Same-address collision: req0 addr=4 JK=10, req1 addr=4 JK=01, both valid, prio=0 -> cycle 1 q[4]=1, cycle 2 q[4]=0, ack0 then ack1.
- Invalid address: req1 addr=7 JK=10 -> q unchanged, addr_err pulse 1 cycle, ack1 pulse, cmd_count+1.
- Saturation and reset mid-run: with CNT_W=3, issue 10 accepts -> cmd_count stops at 7. Then assert reset between edges with q=101101 -> q=0 and qb=111111 immediately without a clock edge, and prio=0 afterwards.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// Bank of N_BITS JK cells behind one shared update port, arbitrated
// round-robin between two requesters.
module jk_bank_arbiter #(
  parameter int N_BITS = 6,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic              req0_j,
  input  logic              req0_k,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic              req1_j,
  input  logic              req1_k,
  output logic              req1_ready,
  output logic [N_BITS-1:0] q,
  output logic [N_BITS-1:0] qb,
  output logic              ack0,
  output logic              ack1,
  output logic              addr_err,
  output logic [CNT_W-1:0]  cmd_count
);

  // Handshake: a command is accepted on a rising edge where valid && ready;
  // ready is combinational, never asserts without its own valid, never for
  // both requesters at once, and is held low while reset is high.

  localparam logic [ADDR_W:0] LP_N_BITS = (ADDR_W+1)'(N_BITS);

  logic              r_prio;
  logic [N_BITS-1:0] r_q;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_addr_err;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_grant0;
  logic              w_grant1;
  logic              w_accept;
  logic              w_addr_ok;
  logic              w_j;
  logic              w_k;
  logic [ADDR_W-1:0] w_addr;
  logic [N_BITS-1:0] w_q_next;

  always_comb begin
    w_grant0 = !reset && req0_valid && (!req1_valid || !r_prio);
    w_grant1 = !reset && req1_valid && (!req0_valid ||  r_prio);
    w_accept = w_grant0 || w_grant1;
    if (w_grant1) begin
      w_addr = req1_addr;
      w_j    = req1_j;
      w_k    = req1_k;
    end else begin
      w_addr = req0_addr;
      w_j    = req0_j;
      w_k    = req0_k;
    end
    w_addr_ok = {1'b0, w_addr} < LP_N_BITS;
  end

  always_comb begin
    w_q_next = r_q;
    for (int i = 0; i < N_BITS; i++) begin
      if (w_addr_ok && w_addr == ADDR_W'(i)) begin
        case ({w_j, w_k})
          2'b01:   w_q_next[i] = 1'b0;
          2'b10:   w_q_next[i] = 1'b1;
          2'b11:   w_q_next[i] = ~r_q[i];
          default: w_q_next[i] = r_q[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prio     <= 1'b0;
      r_q        <= '0;
      r_ack0     <= 1'b0;
      r_ack1     <= 1'b0;
      r_addr_err <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_ack0     <= w_grant0;
      r_ack1     <= w_grant1;
      r_addr_err <= w_accept && !w_addr_ok;
      if (w_accept) begin
        r_q <= w_q_next;
      end
      if (w_accept && r_cnt != '1) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      // Under contention the favoured side always wins, so flipping here
      // yields strict alternation; single-requester grants keep priority.
      if (req0_valid && req1_valid) begin
        r_prio <= ~r_prio;
      end
    end
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;
  assign q          = r_q;
  assign qb         = ~r_q;
  assign ack0       = r_ack0;
  assign ack1       = r_ack1;
  assign addr_err   = r_addr_err;
  assign cmd_count  = r_cnt;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_jk_bank_arbiter;

  localparam int N  = 6;
  localparam int AW = 3;
  localparam int W  = N + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0, req0_j = 1'b0, req0_k = 1'b0;
  logic [AW-1:0] req0_addr = '0;
  logic          req1_valid = 1'b0, req1_j = 1'b0, req1_k = 1'b0;
  logic [AW-1:0] req1_addr = '0;

  logic          a_r0, a_r1, a_ack0, a_ack1, a_err;
  logic [N-1:0]  a_q, a_qb;
  logic [7:0]    a_cnt;
  logic          b_r0, b_r1, b_ack0, b_ack1, b_err;
  logic [N-1:0]  b_q, b_qb;
  logic [2:0]    b_cnt;

  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];
  logic [N-1:0] mq;
  int           mprio;
  int           mcnt;

  jk_bank_arbiter dut_a (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_j(req0_j), .req0_k(req0_k),
    .req0_ready(a_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_j(req1_j), .req1_k(req1_k),
    .req1_ready(a_r1),
    .q(a_q), .qb(a_qb), .ack0(a_ack0), .ack1(a_ack1), .addr_err(a_err), .cmd_count(a_cnt)
  );

  jk_bank_arbiter #(.CNT_W(3)) dut_b (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_j(req0_j), .req0_k(req0_k),
    .req0_ready(b_r0),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_j(req1_j), .req1_k(req1_k),
    .req1_ready(b_r1),
    .q(b_q), .qb(b_qb), .ack0(b_ack0), .ack1(b_ack1), .addr_err(b_err), .cmd_count(b_cnt)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: model state advances at each falling edge using the inputs
  // that will be sampled at the following rising edge.
  always @(negedge clk) begin : compare
    logic [W-1:0]  e;
    logic [N-1:0]  eqb;
    logic          g0, g1;
    logic [AW-1:0] ad;
    logic [1:0]    jk;
    int            ea, eb;
    if (reset) begin
      exp_q.delete();
      mq    = '0;
      mprio = 0;
      mcnt  = 0;
      exp_q.push_back('0);
      chk("rst_q", a_q, 0);
      chk("rst_qb", a_qb, 6'h3f);
      chk("rst_b_qb", b_qb, 6'h3f);
      chk("rst_acks", {a_ack0, a_ack1, a_err}, 0);
      chk("rst_cnt", a_cnt, 0);
      chk("rst_b_cnt", b_cnt, 0);
      chk("rst_ready", {a_r0, a_r1, b_r0, b_r1}, 0);
    end else begin
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 1, 0);
        e = '0;
      end else begin
        e = exp_q.pop_front();
      end
      eqb = ~e[N-1:0];
      ea  = (mcnt > 255) ? 255 : mcnt;
      eb  = (mcnt > 7) ? 7 : mcnt;
      chk("ack0", a_ack0, e[N+2]);
      chk("ack1", a_ack1, e[N+1]);
      chk("addr_err", a_err, e[N]);
      chk("q", a_q, e[N-1:0]);
      chk("qb", a_qb, eqb);
      chk("b_q", b_q, e[N-1:0]);
      chk("b_qb", b_qb, eqb);
      chk("b_acks", {b_ack0, b_ack1, b_err}, e[N+2:N]);
      chk("cmd_count", a_cnt, ea);
      chk("b_cmd_count_sat", b_cnt, eb);
      g0 = req0_valid && (!req1_valid || mprio == 0);
      g1 = req1_valid && (!req0_valid || mprio == 1);
      chk("ready0", a_r0, g0);
      chk("ready1", a_r1, g1);
      chk("b_ready", {b_r0, b_r1}, {g0, g1});
      if (g1) begin
        ad = req1_addr;
        jk = {req1_j, req1_k};
      end else begin
        ad = req0_addr;
        jk = {req0_j, req0_k};
      end
      if (g0 || g1) begin
        mcnt++;
        if (int'(ad) < N) begin
          case (jk)
            2'b01:   mq[ad] = 1'b0;
            2'b10:   mq[ad] = 1'b1;
            2'b11:   mq[ad] = ~mq[ad];
            default: ;
          endcase
        end
      end
      if (req0_valid && req1_valid) mprio = 1 - mprio;
      exp_q.push_back({g0, g1, (g0 || g1) && (int'(ad) >= N), mq});
    end
  end

  // Driver tasks: inputs change 2 time units after a rising edge.
  task automatic do_reset();
    reset = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rst_ready_gated", {a_r0, a_r1}, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("rst_hold_q", a_q, 0);
    chk("rst_hold_qb", a_qb, 6'h3f);
    chk("rst_hold_cnt", a_cnt, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic cyc(input logic v0, input logic [AW-1:0] a0, input logic [1:0] jk0,
                     input logic v1, input logic [AW-1:0] a1, input logic [1:0] jk1);
    req0_valid = v0; req0_addr = a0; {req0_j, req0_k} = jk0;
    req1_valid = v1; req1_addr = a1; {req1_j, req1_k} = jk1;
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic r0s, r1s;
    do_reset();

    // Single requester on cell 2
    cyc(1, 2, 2'b10, 0, 0, 2'b00);
    chk("s_set_q", a_q, 6'b000100);
    chk("s_ack0", {a_ack0, a_ack1}, 2'b10);
    cyc(0, 0, 2'b00, 0, 0, 2'b00);
    chk("s_ack0_once", a_ack0, 0);
    cyc(1, 2, 2'b11, 0, 0, 2'b00);
    chk("s_tog0", a_q, 6'b000000);
    cyc(1, 2, 2'b11, 0, 0, 2'b00);
    chk("s_tog1", a_q, 6'b000100);
    cyc(1, 2, 2'b01, 0, 0, 2'b00);
    chk("s_clr", a_q, 6'b000000);
    cyc(1, 2, 2'b00, 0, 0, 2'b00);
    chk("s_hold", a_q, 6'b000000);
    chk("s_count", a_cnt, 5);

    // Contention: strict alternation starting with requester 0
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 2'b11, 1, 1, 2'b11);
      chk("c_grant_order", {a_ack0, a_ack1}, (i % 2 == 0) ? 2'b10 : 2'b01);
    end
    chk("c_q", a_q, 6'b000011);
    chk("c_count", a_cnt, 6);

    // Same-address collision, then an out-of-range address
    do_reset();
    cyc(1, 4, 2'b10, 1, 4, 2'b01);
    chk("sa_first", {a_ack0, a_ack1, a_q}, {2'b10, 6'b010000});
    cyc(0, 0, 2'b00, 1, 4, 2'b01);
    chk("sa_second", {a_ack0, a_ack1, a_q}, {2'b01, 6'b000000});
    cyc(0, 0, 2'b00, 1, 7, 2'b10);
    chk("ia_pulse", {a_err, a_ack1, a_q}, {2'b11, 6'b000000});
    chk("ia_count", a_cnt, 3);
    cyc(0, 0, 2'b00, 0, 0, 2'b00);
    chk("ia_err_once", a_err, 0);

    // Saturation of the narrow counter
    do_reset();
    repeat (10) cyc(1, 0, 2'b00, 0, 0, 2'b00);
    chk("sat_b", b_cnt, 7);
    chk("sat_a", a_cnt, 10);

    // Async reset between edges with q = 101101 and prio moved to 1
    cyc(1, 0, 2'b10, 0, 0, 2'b00);
    cyc(1, 2, 2'b10, 0, 0, 2'b00);
    cyc(1, 3, 2'b10, 0, 0, 2'b00);
    cyc(1, 5, 2'b10, 0, 0, 2'b00);
    chk("mr_q_before", a_q, 6'b101101);
    cyc(1, 0, 2'b00, 1, 1, 2'b00);
    chk("mr_prio_flip", {a_ack0, a_ack1}, 2'b10);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("mr_q_async", a_q, 0);
    chk("mr_qb_async", a_qb, 6'h3f);
    chk("mr_b_q_async", b_q, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    cyc(1, 0, 2'b00, 1, 1, 2'b00);
    chk("mr_prio_reset", {a_ack0, a_ack1}, 2'b10);
    cyc(0, 0, 2'b00, 0, 0, 2'b00);

    // Randomized traffic; a pending command stays valid until accepted
    r0s = 1'b0;
    r1s = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!req0_valid || r0s) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        req0_addr  = AW'($urandom_range(0, 7));
        {req0_j, req0_k} = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        {req0_j, req0_k} = 2'($urandom_range(0, 3));
      end
      if (!req1_valid || r1s) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        req1_addr  = AW'($urandom_range(0, 7));
        {req1_j, req1_k} = 2'($urandom_range(0, 3));
      end else if ($urandom_range(0, 3) == 0) begin
        req1_addr = AW'($urandom_range(0, 7));
      end
      reset = ($urandom_range(0, 299) == 0);
      #1;
      r0s = a_r0;
      r1s = a_r1;
      @(posedge clk);
      #2;
    end
    reset = 1'b0;
    cyc(0, 0, 2'b00, 0, 0, 2'b00);
    cyc(0, 0, 2'b00, 0, 0, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
